// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use stall, redirect
// flush, EX-stage forwarding selects, ID same-cycle WB bypass and event counters.
module pipe_hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  id_wr_i,
    input  logic        id_rf_we_i,
    input  logic        id_is_load_i,
    input  logic        ex_redirect_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        flush_id_o,
    output logic        bubble_ex_o,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o,
    output logic        id_byp_a_o,
    output logic        id_byp_b_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] wr;
        logic       we;
        logic       load;
    } slot_t;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    slot_t      ex_q, mem_q, wb_q;
    logic [4:0] ex_rs1_q, ex_rs2_q;
    logic       ex_rs1_used_q, ex_rs2_used_q;
    logic       load_use;

    // x0 is never a real destination, so it can never create a dependency.
    function automatic logic is_writing(input slot_t s);
        return s.valid && s.we && (s.wr != 5'd0);
    endfunction

    // A MEM-stage load has no data yet, so it is skipped and WB may match instead.
    function automatic logic [1:0] pick_fwd(input logic used, input logic [4:0] src,
                                            input slot_t m, input slot_t w);
        if (!used)
            return FWD_RD;
        if (is_writing(m) && !m.load && (m.wr == src))
            return FWD_MEM;
        if (is_writing(w) && (w.wr == src))
            return FWD_WB;
        return FWD_RD;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        load_use    = 1'b0;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        flush_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        fwd_a_o     = FWD_RD;
        fwd_b_o     = FWD_RD;
        id_byp_a_o  = 1'b0;
        id_byp_b_o  = 1'b0;
        if (!rst_i) begin
            load_use = id_valid_i && is_writing(ex_q) && ex_q.load &&
                       ((id_rs1_used_i && (id_rs1_i == ex_q.wr)) ||
                        (id_rs2_used_i && (id_rs2_i == ex_q.wr)));
            // A redirect squashes the stalled instruction, so it wins over load-use.
            flush_id_o  = ex_redirect_i;
            stall_if_o  = load_use && !ex_redirect_i;
            stall_id_o  = load_use && !ex_redirect_i;
            bubble_ex_o = ex_redirect_i || load_use;
            if (ex_q.valid) begin
                fwd_a_o = pick_fwd(ex_rs1_used_q, ex_rs1_q, mem_q, wb_q);
                fwd_b_o = pick_fwd(ex_rs2_used_q, ex_rs2_q, mem_q, wb_q);
            end
            id_byp_a_o = is_writing(wb_q) && id_rs1_used_i && (wb_q.wr == id_rs1_i);
            id_byp_b_o = is_writing(wb_q) && id_rs2_used_i && (wb_q.wr == id_rs2_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the slot shift reads pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble_ex_o) begin
                ex_q          <= '0;
                ex_rs1_q      <= '0;
                ex_rs2_q      <= '0;
                ex_rs1_used_q <= 1'b0;
                ex_rs2_used_q <= 1'b0;
            end else begin
                ex_q          <= '{valid: id_valid_i, wr: id_wr_i, we: id_rf_we_i, load: id_is_load_i};
                ex_rs1_q      <= id_rs1_i;
                ex_rs2_q      <= id_rs2_i;
                ex_rs1_used_q <= id_rs1_used_i;
                ex_rs2_used_q <= id_rs2_used_i;
            end
            if (stall_id_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_id_o && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// random traffic, all compared against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i;
    logic        id_rs1_used_i, id_rs2_used_i;
    logic [4:0]  id_wr_i;
    logic        id_rf_we_i, id_is_load_i, ex_redirect_i;
    logic        stall_if_o, stall_id_o, flush_id_o, bubble_ex_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic        id_byp_a_o, id_byp_b_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_wr_i(id_wr_i), .id_rf_we_i(id_rf_we_i), .id_is_load_i(id_is_load_i),
        .ex_redirect_i(ex_redirect_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .flush_id_o(flush_id_o),
        .bubble_ex_o(bubble_ex_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .id_byp_a_o(id_byp_a_o), .id_byp_b_o(id_byp_b_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // One in-flight instruction as the program sees it.
    typedef struct {
        bit       valid;
        bit [4:0] wr;
        bit       we;
        bit       load;
        bit [4:0] rs1;
        bit       u1;
        bit [4:0] rs2;
        bit       u2;
    } instr_t;

    instr_t pipe [3];            // 0 = EX, 1 = MEM, 2 = WB
    longint m_stall, m_flush;
    bit     cnt_known = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;

    function automatic instr_t ins(bit v, bit [4:0] wr, bit we, bit ld,
                                   bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2);
        instr_t i;
        i.valid = v; i.wr = wr; i.we = we; i.load = ld;
        i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        return i;
    endfunction

    function automatic instr_t nop();
        return ins(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit produces(instr_t s);
        return s.valid && s.we && (s.wr != 0);
    endfunction

    // Where the EX instruction should get a source from: newest ready producer wins.
    function automatic bit [1:0] src_of(bit [4:0] r, bit used);
        if (!used || !pipe[0].valid) return 2'd0;
        if (produces(pipe[1]) && !pipe[1].load && pipe[1].wr == r) return 2'd1;
        if (produces(pipe[2]) && pipe[2].wr == r) return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one ID-stage cycle, check the combinational decisions, then clock the model.
    task automatic step(string tag, instr_t id, bit redirect, bit rst);
        bit lu, e_stall, e_flush, e_bypa, e_bypb;
        bit [1:0] e_fa, e_fb;
        id_valid_i = id.valid; id_wr_i = id.wr; id_rf_we_i = id.we; id_is_load_i = id.load;
        id_rs1_i = id.rs1; id_rs1_used_i = id.u1; id_rs2_i = id.rs2; id_rs2_used_i = id.u2;
        ex_redirect_i = redirect;
        rst_i = rst;
        #1;
        lu = !rst && id.valid && produces(pipe[0]) && pipe[0].load &&
             ((id.u1 && id.rs1 == pipe[0].wr) || (id.u2 && id.rs2 == pipe[0].wr));
        e_flush = !rst && redirect;
        e_stall = lu && !redirect;
        e_fa    = rst ? 2'd0 : src_of(pipe[0].rs1, pipe[0].u1);
        e_fb    = rst ? 2'd0 : src_of(pipe[0].rs2, pipe[0].u2);
        e_bypa  = !rst && produces(pipe[2]) && id.u1 && pipe[2].wr == id.rs1;
        e_bypb  = !rst && produces(pipe[2]) && id.u2 && pipe[2].wr == id.rs2;
        chk({tag, ".stall_if"}, stall_if_o, e_stall);
        chk({tag, ".stall_id"}, stall_id_o, e_stall);
        chk({tag, ".flush_id"}, flush_id_o, e_flush);
        chk({tag, ".bubble_ex"}, bubble_ex_o, e_stall || e_flush);
        chk({tag, ".fwd_a"}, fwd_a_o, e_fa);
        chk({tag, ".fwd_b"}, fwd_b_o, e_fb);
        chk({tag, ".byp_a"}, id_byp_a_o, e_bypa);
        chk({tag, ".byp_b"}, id_byp_b_o, e_bypb);
        if (cnt_known) begin
            chk({tag, ".stall_cnt"}, stall_cnt_o, m_stall[31:0]);
            chk({tag, ".flush_cnt"}, flush_cnt_o, m_flush[31:0]);
        end
        @(posedge clk_i);
        if (rst) begin
            pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
            m_stall = 0; m_flush = 0; cnt_known = 1'b1;
        end else begin
            if (e_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_flush && m_flush < 64'hFFFF_FFFF) m_flush++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (e_stall || e_flush) ? nop() : id;
        end
        @(negedge clk_i);
    endtask

    initial begin
        instr_t hz;
        pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
        m_stall = 0; m_flush = 0;
        @(negedge clk_i);

        // Reset, including hazard-looking inputs and a redirect while held in reset.
        hz = ins(1, 3, 1, 1, 3, 1, 3, 1);
        step("rst0", hz, 1, 1);
        step("rst1", hz, 1, 1);
        step("post_rst", nop(), 0, 0);

        // RAW: add x5; add x6,x5,x5; add x7,x5,x0.
        step("raw_p", ins(1, 5, 1, 0, 1, 1, 2, 1), 0, 0);
        step("raw_c1", ins(1, 6, 1, 0, 5, 1, 5, 1), 0, 0);
        step("raw_c2", ins(1, 7, 1, 0, 5, 1, 0, 1), 0, 0);
        step("raw_chk", nop(), 0, 0);
        step("raw_drain", nop(), 0, 0);

        // Load-use: lw x7; dependent stalls one cycle, is held, then forwards from WB.
        step("lu_lw", ins(1, 7, 1, 1, 1, 1, 0, 0), 0, 0);
        step("lu_stall", ins(1, 8, 1, 0, 7, 1, 0, 0), 0, 0);
        step("lu_held", ins(1, 8, 1, 0, 7, 1, 0, 0), 0, 0);
        step("lu_fwd", nop(), 0, 0);
        step("lu_drain", nop(), 0, 0);

        // Redirect for one cycle with a producer in flight.
        step("rd_p", ins(1, 10, 1, 0, 0, 0, 0, 0), 0, 0);
        step("rd_flush", ins(1, 11, 1, 0, 10, 1, 0, 0), 1, 0);
        step("rd_after", ins(1, 12, 1, 0, 11, 1, 0, 0), 0, 0);

        // Load-use and redirect together: flush only.
        step("sim_lw", ins(1, 3, 1, 1, 0, 0, 0, 0), 0, 0);
        step("sim_both", ins(1, 4, 1, 0, 3, 1, 3, 1), 1, 0);
        step("sim_after", nop(), 0, 0);

        // x0 never stalls or forwards.
        step("x0_lw", ins(1, 0, 1, 1, 0, 0, 0, 0), 0, 0);
        step("x0_rd1", ins(1, 0, 1, 0, 0, 1, 0, 1), 0, 0);
        step("x0_rd2", ins(1, 13, 1, 0, 0, 1, 0, 1), 0, 0);
        step("x0_chk", nop(), 0, 0);

        // WB bypass: add x9 reaches WB three cycles later while ID reads x9 on rs2.
        step("byp_p", ins(1, 9, 1, 0, 0, 0, 0, 0), 0, 0);
        step("byp_n1", nop(), 0, 0);
        step("byp_n2", nop(), 0, 0);
        step("byp_rd", ins(1, 14, 1, 0, 1, 1, 9, 1), 0, 0);

        // Reset asserted during a load-use stall.
        step("rms_lw", ins(1, 4, 1, 1, 0, 0, 0, 0), 0, 0);
        step("rms_stall", ins(1, 5, 1, 0, 4, 1, 0, 0), 0, 1);
        step("rms_after", ins(1, 5, 1, 0, 4, 1, 0, 0), 0, 0);

        // Counter saturation from a preloaded value.
        force dut.stall_cnt_o = 32'hFFFF_FFFE;
        force dut.flush_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_o;
        release dut.flush_cnt_o;
        m_stall = 64'hFFFF_FFFE;
        m_flush = 64'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            step("sat_lw", ins(1, 6, 1, 1, 0, 0, 0, 0), 0, 0);
            step("sat_stall", ins(1, 7, 1, 0, 0, 0, 6, 1), 0, 0);
        end
        step("sat_flush", nop(), 1, 0);
        step("sat_end", nop(), 0, 0);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            instr_t r;
            r = ins($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                    5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
                    5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
            step("rand", r, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have ports id_valid_i (1), id_rs1_i (5), id_rs2_i (5), id_rs1_used_i (1), id_rs2_used_i (1), all inputs: ID-stage instruction and source operands.
REQ-004 SHALL have ports id_wr_i (5), id_rf_we_i (1), id_is_load_i (1), all inputs: ID-stage destination, register-file write enable, and a load flag (wd_sel 001/010/011).
REQ-005 SHALL have port ex_redirect_i, input, 1: the EX-stage branch/jump is taken, so npc is not sequential.
REQ-006 SHALL have ports stall_if_o (1) and stall_id_o (1), outputs: hold PC and hold IF/ID.
REQ-007 SHALL have port flush_id_o, output, 1: load a bubble into IF/ID (have_inst=0, rf_we=0, dram_we=0).
REQ-008 SHALL have port bubble_ex_o, output, 1: load a bubble into ID/EX.
REQ-009 SHALL have ports fwd_a_o (2) and fwd_b_o (2), outputs: EX operand source; 00 = ID/EX rd, 01 = EX/MEM aluc, 10 = MEM/WB rf_wd, 11 unused.
REQ-010 SHALL have ports id_byp_a_o (1) and id_byp_b_o (1), outputs: the ID read takes rf_wd instead of rf_rd (same-cycle WB write).
REQ-011 SHALL have ports stall_cnt_o (32) and flush_cnt_o (32), outputs: performance counters.

Function
REQ-012 SHALL keep a shadow pipeline of three slots (EX, MEM, WB). Each slot holds valid, wr, we, load; the EX slot additionally holds rs1, rs2, rs1_used, rs2_used.
REQ-013 A slot SHALL be "writing" only when valid=1, we=1 and wr!=0; x0 SHALL never cause a hazard, forward or bypass.
REQ-014 Load-use condition SHALL be: id_valid_i, the EX slot writing with load=1, and an ID source (used=1) equal to the EX slot wr.
REQ-015 On load-use without a redirect: stall_if_o=stall_id_o=bubble_ex_o=1 and flush_id_o=0, for exactly the cycle the condition holds. The stall is never extended beyond one cycle unless a new hazard occurs.
REQ-016 When ex_redirect_i=1: flush_id_o=bubble_ex_o=1 and stall_if_o=stall_id_o=0. Redirect SHALL take priority over load-use (the stalled instruction is itself squashed).
REQ-017 Slot advance each edge:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields (valid=id_valid_i) only when no stall and no redirect; otherwise EX<=bubble (valid=0).
REQ-018 fwd_a_o selection for the EX-slot rs1 (when rs1_used=1):
  - 01 if the MEM slot is writing, non-load, and wr matches;
  - else 10 if the WB slot is writing and matches;
  - else 00.
  - MEM takes priority over WB. fwd_b_o is the same for rs2.
REQ-019 A MEM-slot load matching an EX source SHALL select 00/10, never 01. This case is unreachable given REQ-015.
REQ-020 id_byp_a_o=1 iff the WB slot is writing and wr==id_rs1_i with id_rs1_used_i=1; id_byp_b_o is the same for rs2.
REQ-021 All stall/flush/bubble/fwd/byp outputs SHALL be combinational from slot state and current inputs; decision latency is 0 cycles.
REQ-022 stall_cnt_o SHALL increment by 1 on each edge where stall_id_o=1; flush_cnt_o SHALL increment on each edge where flush_id_o=1. Both saturate at 32'hFFFFFFFF with no wrap.
REQ-023 A simultaneous load-use and redirect SHALL count as a flush only.

Reset
REQ-024 When rst_i=1 at an edge, all slots SHALL be invalid and both counters 0, including reset mid-stall or mid-flush.
REQ-025 While rst_i=1, stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, id_byp_a_o and id_byp_b_o SHALL be 0 and fwd_a_o/fwd_b_o SHALL be 00, regardless of inputs.
REQ-026 On the first cycle after reset, outputs SHALL be 0/00 unless ex_redirect_i=1.

Verification
REQ-027 RAW forward: ID "add x5" then next ID "add x6,x5,x5" -> next cycle fwd_a_o=fwd_b_o=01; one cycle later (third instr uses x5) fwd_a_o=10.
REQ-028 Load-use: "lw x7" in EX, ID rs1=x7 used -> stall_if_o=stall_id_o=bubble_ex_o=1 for 1 cycle; stall_cnt_o 0->1; dependent then in EX with fwd_a_o=10.
REQ-029 Redirect: ex_redirect_i=1 for 1 cycle -> flush_id_o=bubble_ex_o=1 that cycle; flush_cnt_o +1; EX slot invalid next cycle (no forward from it).
REQ-030 Simultaneous: load-use condition and ex_redirect_i=1 -> stall_*=0, flush_id_o=1; stall_cnt_o unchanged, flush_cnt_o +1.
REQ-031 x0 and WB bypass: "lw x0"/"add x0" followed by readers of x0 -> no stall, fwd 00; WB slot writing x9 with ID rs2=x9 -> id_byp_b_o=1.
REQ-032 Reset mid-stall: assert rst_i during a load-use stall -> next cycle all outputs 0, counters 0; counter preloaded near 32'hFFFFFFFF saturates.
